pwm_seq: RTL and testbench

PWM_SEQ -- requirements
Module: pwm_seq

---
 rtl/pwm_seq.sv | 207 ++++++++++++++++++++
 tb/tb_pwm_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_seq.sv
// pwm_seq: APB-programmed compare sequencer for a PWM timer.
// A 4-deep FIFO holds {cmp1,cmp2} pairs. Each pair drives the timer compares
// for REPEAT+1 periods, and then the next pair is taken from the head.
// Optional feature macro: PWM_SEQ_LOOP_EN. It adds CTRL.LOOP, which replays the
// FIFO contents without popping them.
// APB handshake: PREADY is tied high, so every access finishes in its access
// phase. A write commits on PSEL&PWRITE&PENABLE. Reads are combinational on PADDR.
module pwm_seq (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic [19:2] PADDR,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   input  logic        period_end,
   output logic [31:0] TMRCMP1,
   output logic [31:0] TMRCMP2,
   output logic        TMREN,
   output logic        IRQ
);

   localparam logic [17:0] A_CTRL   = 18'h0;
   localparam logic [17:0] A_CMP1   = 18'h1;
   localparam logic [17:0] A_PUSH   = 18'h2;
   localparam logic [17:0] A_STATUS = 18'h3;
   localparam logic [17:0] A_REPEAT = 18'h4;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        seq_en, irq_en;
   logic [31:0] cmp1_stage;
   logic [15:0] repeat_cfg;
   logic [15:0] cnt;
   logic        uf_flag, of_flag;
   logic [63:0] mem [4];
   logic [1:0]  wr_ptr, rd_ptr, ri;
   logic [2:0]  level;

   logic        wr_en, wr_ctrl, wr_cmp1, wr_push, wr_status, wr_repeat;
   logic        flush, loop_mode, loop_rd;
   logic        take, pop, replay, dec, uf_set, of_set, push_ok;
   logic [1:0]  rd_idx;
   logic [63:0] take_data;
   logic [2:0]  ri_inc;

   assign PREADY    = 1'b1;
   assign wr_en     = PSEL & PWRITE & PENABLE;
   assign wr_ctrl   = wr_en && (PADDR == A_CTRL);
   assign wr_cmp1   = wr_en && (PADDR == A_CMP1);
   assign wr_push   = wr_en && (PADDR == A_PUSH);
   assign wr_status = wr_en && (PADDR == A_STATUS);
   assign wr_repeat = wr_en && (PADDR == A_REPEAT);
   assign flush     = wr_ctrl & PWDATA[2];

`ifdef PWM_SEQ_LOOP_EN
   logic ctrl_loop;
   assign loop_mode = ctrl_loop;
   assign loop_rd   = ctrl_loop;

   // LOOP bit storage, present only in the loop-capable build
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)     ctrl_loop <= 1'b0;
      else if (wr_ctrl) ctrl_loop <= PWDATA[1];
   end
`else
   assign loop_mode = 1'b0;
   assign loop_rd   = 1'b0;
`endif

   // A replay takes the entry at ri places past the head. A pop always takes the head.
   assign rd_idx    = loop_mode ? (rd_ptr + ri) : rd_ptr;
   assign take_data = mem[rd_idx];
   assign pop       = take & ~loop_mode;
   assign replay    = take & loop_mode;
   assign ri_inc    = {1'b0, ri} + 3'd1;

   // When the FIFO is full, a push is accepted only if a pop frees a slot in the same cycle. Flush beats push.
   assign push_ok = wr_push && !flush && ((level != 3'd4) || pop);
   assign of_set  = wr_push && !flush && (level == 3'd4) && !pop;

   // Sequencer next-state and action decode
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      dec       = 1'b0;
      uf_set    = 1'b0;
      case (state)
         S_IDLE: begin
            if (seq_en && (level != 3'd0)) begin
               take      = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!seq_en) begin
               state_nxt = S_IDLE;
            end else if (period_end) begin
               if (cnt != 16'd0)        dec    = 1'b1;
               else if (level != 3'd0)  take   = 1'b1;
               else                     uf_set = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Sequencer state register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   assign TMREN = (state == S_RUN);
   assign IRQ   = irq_en & (uf_flag | of_flag);

   // Control and configuration registers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         seq_en     <= 1'b0;
         irq_en     <= 1'b0;
         cmp1_stage <= 32'd0;
         repeat_cfg <= 16'd0;
      end else begin
         if (wr_ctrl) begin
            seq_en <= PWDATA[0];
            irq_en <= PWDATA[3];
         end
         if (wr_cmp1)   cmp1_stage <= PWDATA;
         if (wr_repeat) repeat_cfg <= PWDATA[15:0];
      end
   end

   // Sticky status flags. A new event in the same cycle beats a write-1-to-clear.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         uf_flag <= 1'b0;
         of_flag <= 1'b0;
      end else begin
         if (uf_set)                      uf_flag <= 1'b1;
         else if (wr_status && PWDATA[5]) uf_flag <= 1'b0;
         if (of_set)                      of_flag <= 1'b1;
         else if (wr_status && PWDATA[6]) of_flag <= 1'b0;
      end
   end

   // FIFO storage. The pointers alone define the valid entries, so the storage itself is not reset.
   always_ff @(posedge PCLK) begin
      if (push_ok) mem[wr_ptr] <= {cmp1_stage, PWDATA};
   end

   // FIFO pointers, level and replay index
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         level  <= 3'd0;
         ri     <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         level  <= 3'd0;
         ri     <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 2'd1;
         if (pop)     rd_ptr <= rd_ptr + 2'd1;
         level <= level + {2'b0, push_ok} - {2'b0, pop};
         if (!loop_mode)  ri <= 2'd0;
         else if (replay) ri <= (ri_inc >= level) ? 2'd0 : ri_inc[1:0];
      end
   end

   // Active compares and the repeat counter
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         TMRCMP1 <= 32'd0;
         TMRCMP2 <= 32'd0;
         cnt     <= 16'd0;
      end else if (take) begin
         TMRCMP1 <= take_data[63:32];
         TMRCMP2 <= take_data[31:0];
         cnt     <= repeat_cfg;
      end else if (dec) begin
         cnt <= cnt - 16'd1;
      end else if (uf_set) begin
         cnt <= repeat_cfg;
      end
   end

   // APB read mux
   always_comb begin
      PRDATA = 32'hDEADBEEF;
      case (PADDR)
         A_CTRL:   PRDATA = {28'd0, irq_en, 1'b0, loop_rd, seq_en};
         A_CMP1:   PRDATA = cmp1_stage;
         A_PUSH:   PRDATA = 32'd0;
         A_STATUS: PRDATA = {23'd0, state, 1'b0, of_flag, uf_flag, level,
                             (level == 3'd4), (level == 3'd0)};
         A_REPEAT: PRDATA = {16'd0, repeat_cfg};
         default:  PRDATA = 32'hDEADBEEF;
      endcase
   end

endmodule

// File: tb/tb_pwm_seq.sv
// tb_pwm_seq: directed bench for pwm_seq.
// Define PWM_SEQ_LOOP_EN to build the loop-replay scenario.
module tb_pwm_seq;

   logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE, period_end;
   logic [19:2] PADDR;
   logic [31:0] PWDATA, PRDATA, TMRCMP1, TMRCMP2;
   logic        PREADY, TMREN, IRQ;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_pair;
   logic [31:0] rd;

   pwm_seq dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .period_end(period_end), .TMRCMP1(TMRCMP1),
      .TMRCMP2(TMRCMP2), .TMREN(TMREN), .IRQ(IRQ)
   );

   // clock / reset
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   task automatic apb_write(input logic [17:0] a, input logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PWRITE = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic apb_read(input logic [17:0] a, output logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b1; PADDR = a;
      #1 d = PRDATA;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic push_pair(input logic [31:0] c1, input logic [31:0] c2);
      apb_write(18'h1, c1);
      apb_write(18'h2, c2);
   endtask

   task automatic pulse_pe();
      @(negedge PCLK);
      period_end = 1'b1;
      @(negedge PCLK);
      period_end = 1'b0;
   endtask

   task automatic check_cmp(input string tag, input logic [31:0] c1, input logic [31:0] c2);
      check_eq({tag, ".cmp1"}, TMRCMP1, c1);
      check_eq({tag, ".cmp2"}, TMRCMP2, c2);
   endtask

   initial begin
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; period_end = 1'b0;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;

      // reset values
      check_eq("rst.tmren", {31'd0, TMREN}, 32'd0);
      check_cmp("rst", 32'd0, 32'd0);
      check_eq("rst.irq", {31'd0, IRQ}, 32'd0);
      check_eq("rst.pready", {31'd0, PREADY}, 32'd1);
      apb_read(18'h3, rd); check_eq("rst.status", rd, 32'h1);
      apb_read(18'h0, rd); check_eq("rst.ctrl", rd, 32'h0);
      apb_read(18'h5, rd); check_eq("unmapped", rd, 32'hDEADBEEF);

      // basic sequence, REPEAT=1
      push_pair(32'd10, 32'd20);
      push_pair(32'd30, 32'd40);
      apb_write(18'h4, 32'd1);
      apb_read(18'h3, rd); check_eq("seq.status2", rd, 32'h8);
      apb_write(18'h0, 32'h1);
      check_eq("seq.tmren_pre", {31'd0, TMREN}, 32'd0);
      @(negedge PCLK);
      check_eq("seq.tmren", {31'd0, TMREN}, 32'd1);
      check_cmp("seq.first", 32'd10, 32'd20);
      apb_read(18'h3, rd); check_eq("seq.status_run", rd, 32'h104);
      pulse_pe();
      check_cmp("seq.hold", 32'd10, 32'd20);
      pulse_pe();
      check_cmp("seq.second", 32'd30, 32'd40);
      apb_read(18'h3, rd); check_eq("seq.status_empty", rd, 32'h101);
      apb_write(18'h0, 32'h0);
      @(negedge PCLK);
      check_eq("seq.stop_tmren", {31'd0, TMREN}, 32'd0);
      check_cmp("seq.stop_hold", 32'd30, 32'd40);
      apb_read(18'h3, rd); check_eq("seq.status_idle", rd, 32'h1);

      // underflow and interrupt, REPEAT=0
      do_reset();
      push_pair(32'd5, 32'd6);
      apb_write(18'h0, 32'h9);
      @(negedge PCLK);
      check_cmp("uf.start", 32'd5, 32'd6);
      pulse_pe();
      apb_read(18'h3, rd); check_eq("uf.status", rd, 32'h121);
      check_eq("uf.irq", {31'd0, IRQ}, 32'd1);
      check_cmp("uf.hold", 32'd5, 32'd6);
      apb_write(18'h3, 32'h20);
      check_eq("uf.irq_clr", {31'd0, IRQ}, 32'd0);
      apb_read(18'h3, rd); check_eq("uf.status_clr", rd, 32'h101);

      // overflow: five pushes, the fifth is dropped
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         push_pair(i, 32'd10 + i);
         if (i <= 4) exp_q.push_back({32'(i), 32'd10 + 32'(i)});
      end
      apb_read(18'h3, rd); check_eq("ovf.status", rd, 32'h52);
      apb_write(18'h0, 32'h1);
      @(negedge PCLK);
      exp_pair = exp_q.pop_front();
      check_cmp("ovf.drain0", exp_pair[63:32], exp_pair[31:0]);
      for (int k = 1; k <= 3; k++) begin
         pulse_pe();
         exp_pair = exp_q.pop_front();
         check_cmp($sformatf("ovf.drain%0d", k), exp_pair[63:32], exp_pair[31:0]);
      end
      apb_read(18'h3, rd); check_eq("ovf.status_drained", rd, 32'h141);

      // push into a full FIFO in the same cycle as a pop
      do_reset();
      for (int i = 1; i <= 4; i++) push_pair(i, 32'd10 + i);
      apb_read(18'h3, rd); check_eq("simul.full", rd, 32'h12);
      apb_write(18'h0, 32'h1);
      @(negedge PCLK);
      check_cmp("simul.start", 32'd1, 32'd11);
      push_pair(32'd5, 32'd15);
      apb_write(18'h1, 32'd6);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = 18'h2; PWDATA = 32'd16; PENABLE = 1'b0;
      @(negedge PCLK);
      PENABLE = 1'b1; period_end = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PWRITE = 1'b0; PENABLE = 1'b0; period_end = 1'b0;
      apb_read(18'h3, rd); check_eq("simul.status", rd, 32'h112);
      check_cmp("simul.pop", 32'd2, 32'd12);

      // reset in the middle of RUN with three entries queued
      pulse_pe();
      apb_read(18'h3, rd); check_eq("midrst.level3", rd, 32'h10C);
      @(negedge PCLK);
      PRESETn = 1'b0;
      #1;
      check_eq("midrst.tmren", {31'd0, TMREN}, 32'd0);
      check_cmp("midrst", 32'd0, 32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      apb_read(18'h3, rd); check_eq("midrst.status", rd, 32'h1);

      // readback and flush
      apb_write(18'h1, 32'd7);
      apb_read(18'h1, rd); check_eq("rb.cmp1", rd, 32'd7);
      apb_write(18'h4, 32'hABCD1234);
      apb_read(18'h4, rd); check_eq("rb.repeat", rd, 32'h1234);
      push_pair(32'd7, 32'd8);
      push_pair(32'd9, 32'd10);
      apb_read(18'h3, rd); check_eq("flush.pre", rd, 32'h8);
      apb_write(18'h0, 32'hC);
      apb_read(18'h0, rd); check_eq("flush.ctrl", rd, 32'h8);
      apb_read(18'h3, rd); check_eq("flush.status", rd, 32'h1);

`ifdef PWM_SEQ_LOOP_EN
      // loop replay of two entries
      do_reset();
      push_pair(32'd100, 32'd200);
      push_pair(32'd300, 32'd400);
      apb_write(18'h0, 32'h3);
      @(negedge PCLK);
      check_cmp("loop.0", 32'd100, 32'd200);
      for (int k = 1; k <= 5; k++) begin
         pulse_pe();
         if (k % 2 == 1) check_cmp($sformatf("loop.%0d", k), 32'd300, 32'd400);
         else            check_cmp($sformatf("loop.%0d", k), 32'd100, 32'd200);
      end
      apb_read(18'h3, rd); check_eq("loop.status", rd, 32'h108);
`else
      // CTRL bit1 reads back as 0 without loop support
      apb_write(18'h0, 32'h2);
      apb_read(18'h0, rd); check_eq("noloop.ctrl", rd, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
